// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Receives a framed program image over a byte stream and writes it into the
// CPU program memory, holding the CPU in reset until a complete frame has
// been loaded.
//
// Frame: 0xA5, N, N data bytes[, checksum = XOR of the data bytes]
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  defined   -> trailing checksum byte expected and
//                                         checked before the CPU is released
//                            undefined -> no checksum byte; the CPU is released
//                                         right after the N-th data byte
//
// Parameters:
//   MEM_DEPTH  number of 8-bit program words (2..256)
//   ADDR_W     program memory address width (2**ADDR_W >= MEM_DEPTH)
//   TIMEOUT    maximum idle cycles between bytes inside a frame (1..65535)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   mem_we     out  program memory write strobe
//   mem_addr   out  program memory write address
//   mem_wdata  out  program memory write data
//   cpu_reset  out  CPU reset, low only while the loaded program runs
//   load_done  out  one-cycle pulse on a successful load
//   load_err   out  one-cycle pulse on an aborted load
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int unsigned MEM_DEPTH = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned TMO_W  = 16;
   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [BYTE_W-1:0]   len_q, len_d;
   logic [BYTE_W-1:0]   idx_q, idx_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]   csum_q, csum_d;
`endif
   logic                rx_ready_q;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                cpu_reset_q;
   logic                load_done_q, load_done_d;
   logic                load_err_q;

   logic                xfer;
   logic                last_byte;
   logic                tmo_hit;
   logic                len_bad;

   assign xfer      = rx_valid && rx_ready_q;
   assign last_byte = (idx_q + 8'd1) == len_q;
   // Idle cycle that would bring the in-frame counter up to TIMEOUT.
   assign tmo_hit   = (32'(tmo_q) + 32'd1) >= TIMEOUT;
   assign len_bad   = (rx_data == 8'd0) || (32'(rx_data) > MEM_DEPTH);

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_done_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_RUN: begin
            tmo_d = '0;
            if (xfer && rx_data == SYNC_BYTE) begin
               state_d = S_LEN;
            end
         end

         S_LEN: begin
            if (xfer) begin
               tmo_d = '0;
               if (len_bad) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = rx_data;
                  idx_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_d  = '0;
`endif
                  state_d = S_DATA;
               end
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end

         S_DATA: begin
            if (xfer) begin
               tmo_d       = '0;
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(idx_q);
               mem_wdata_d = rx_data;
               idx_d       = idx_q + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d      = csum_q ^ rx_data;
               if (last_byte) begin
                  state_d = S_CSUM;
               end
`else
               if (last_byte) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
               end
`endif
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end

`ifdef PROG_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               tmo_d = '0;
               if (rx_data == csum_q) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
               end else begin
                  state_d = S_ERR;
               end
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
`endif

         S_ERR: begin
            tmo_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; flags are derived from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
         rx_ready_q  <= (state_d != S_ERR);
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_reset_q <= (state_d != S_RUN);
         load_done_q <= load_done_d;
         load_err_q  <= (state_d == S_ERR);
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Frames are described at frame level
// (length, payload, checksum good/bad) and the expected writes, pulses and
// CPU reset level are derived from those frame rules. Works with and without
// PROG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_prog_loader;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned TMO   = 40;

   logic          clk;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          cpu_reset;
   logic          load_done;
   logic          load_err;

   prog_loader #(
      .MEM_DEPTH (DEPTH),
      .ADDR_W    (AW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .load_done (load_done),
      .load_err  (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Expected program memory and what the DUT actually wrote.
   logic [7:0] model_mem [DEPTH] = '{default: 8'h00};
   logic [7:0] shadow    [DEPTH] = '{default: 8'h00};
   int we_cnt = 0, done_cnt = 0, err_cnt = 0;
   int exp_we = 0, exp_done = 0, exp_err = 0;
   bit running = 1'b0;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         shadow[mem_addr] = mem_wdata;
         we_cnt++;
      end
      if (load_done === 1'b1) done_cnt++;
      if (load_err === 1'b1)  err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Deliver one byte and check the registered response one cycle later.
   task automatic send(input logic [7:0] b, input bit e_we, input logic [7:0] e_addr,
                       input bit e_done, input bit e_err, input bit e_cpu, input int gap);
      repeat (gap) begin @(posedge clk); #1; end
      for (int g = 0; g < 4 && rx_ready !== 1'b1; g++) begin
         @(posedge clk); #1;
      end
      chk("ready_before_byte", rx_ready, 1);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("mem_wdata", mem_wdata, b);
      end
      chk("load_done", load_done, e_done);
      chk("load_err", load_err, e_err);
      chk("cpu_reset", cpu_reset, e_cpu);
      if (e_err) chk("rx_ready_in_err", rx_ready, 0);
   endtask

   task automatic garbage(input logic [7:0] b, input int gap);
      logic [7:0] v;
      v = (b == 8'hA5) ? 8'h5A : b;
      send(v, 0, 0, 0, 0, !running, gap);
   endtask

   task automatic run_frame(input logic [7:0] n, input logic [7:0] data[$], input bit bad);
      logic [7:0] x;
      bit last;
      int gap;
      send(8'hA5, 0, 0, 0, 0, 1, $urandom_range(0, 2));
      running = 1'b0;
      if (n == 8'd0 || 32'(n) > DEPTH) begin
         send(n, 0, 0, 0, 1, 1, $urandom_range(0, 2));
         exp_err++;
         return;
      end
      send(n, 0, 0, 0, 0, 1, $urandom_range(0, 2));
      x = 8'h00;
      for (int i = 0; i < int'(n); i++) begin
         model_mem[i] = data[i];
         x ^= data[i];
         exp_we++;
`ifdef PROG_LOADER_CHECKSUM_EN
         last = 1'b0;
`else
         last = (i == int'(n) - 1);
`endif
         gap = $urandom_range(0, 3);
         send(data[i], 1, 8'(i), last, 0, !last, gap);
         if (last) begin
            running = 1'b1;
            exp_done++;
         end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(bad ? (x ^ 8'h33) : x, 0, 0, !bad, bad, bad, $urandom_range(0, 3));
      if (bad) exp_err++;
      else begin
         running = 1'b1;
         exp_done++;
      end
`else
      x = x ^ 8'(bad);
`endif
   endtask

   initial begin
      logic [7:0] q[$];
      int k;
      int r;
      logic [7:0] n;

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_err", load_err, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", rx_ready, 1);

      // Three-byte frame with correct checksum
      q = {}; q.push_back(8'h1C); q.push_back(8'h2D); q.push_back(8'h3E);
      run_frame(8'd3, q, 1'b0);

      // Leading junk, then a single-word frame (starts from RUN)
      q = {}; q.push_back(8'h80);
      garbage(8'h00, 0);
      garbage(8'hFF, 0);
      run_frame(8'd1, q, 1'b0);

      // Checksum mismatch (11^22=33, sent 00)
      q = {}; q.push_back(8'h11); q.push_back(8'h22);
      run_frame(8'd2, q, 1'b1);
      garbage(8'h00, 0);

      // Length out of range, and zero length
      q = {};
      run_frame(8'h11, q, 1'b0);
      run_frame(8'h00, q, 1'b0);

      // Maximum length frame
      q = {};
      for (int i = 0; i < int'(DEPTH); i++) q.push_back(8'($urandom));
      run_frame(8'(DEPTH), q, 1'b0);

      // Inter-byte timeout inside a frame
      send(8'hA5, 0, 0, 0, 0, 1, 1);
      running = 1'b0;
      send(8'h04, 0, 0, 0, 0, 1, 0);
      model_mem[0] = 8'h01;
      exp_we++;
      send(8'h01, 1, 0, 0, 0, 1, 0);
      k = 0;
      while (load_err !== 1'b1 && k < int'(TMO) + 10) begin
         @(posedge clk); #1;
         k++;
      end
      exp_err++;
      chk("timeout_cycles", k, TMO);
      chk("timeout_rx_ready", rx_ready, 0);
      chk("timeout_cpu_reset", cpu_reset, 1);

      // Reset in the middle of DATA, coinciding with a byte transfer
      send(8'hA5, 0, 0, 0, 0, 1, 2);
      send(8'h04, 0, 0, 0, 0, 1, 0);
      model_mem[0] = 8'h77;
      exp_we++;
      send(8'h77, 1, 0, 0, 0, 1, 0);
      rx_data  = 8'h99;
      rx_valid = 1'b1;
      reset    = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk("rst_mid_we_dropped", mem_we, 0);
      chk("rst_mid_no_err", load_err, 0);
      chk("rst_mid_cpu_reset", cpu_reset, 1);
      chk("rst_mid_rx_ready", rx_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_ready_rise", rx_ready, 1);
      chk("rst_mid_cpu_reset2", cpu_reset, 1);
      running = 1'b0;

      // Randomised mix of frames and junk
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         q = {};
         if (r == 0) begin
            garbage(8'($urandom), $urandom_range(0, 3));
         end else if (r == 1) begin
            n = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255));
            run_frame(n, q, 1'b0);
         end else begin
            n = 8'($urandom_range(1, DEPTH));
            for (int i = 0; i < int'(n); i++) q.push_back(8'($urandom));
            run_frame(n, q, r == 2);
         end
      end

      @(negedge clk); #1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         chk($sformatf("mem[%0d]", i), shadow[i], model_mem[i]);
      end
      chk("write_count", we_cnt, exp_we);
      chk("done_count", done_cnt, exp_done);
      chk("err_count", err_cnt, exp_err);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
